// File: rtl/spi_reg_bridge.sv
// Command/register layer behind the 16-bit SPI slave transceiver.
// It decodes two-word write/read transactions into 8 control and 8 status registers.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | waiting for a command word
// WR_DATA  | write command accepted, waiting for the data word
// RD_DUMMY | read response loaded, discarding the master's second word
module spi_reg_bridge (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         spi_cs_n,
    input  logic         spi_clk_error,
    input  logic         rx_data_ready,
    input  logic [15:0]  rx_data,
    output logic         tx_data_ready,
    output logic [15:0]  tx_data,
    input  logic [127:0] status_in,
    output logic [127:0] ctrl_regs,
    output logic         wr_strobe,
    output logic [2:0]   wr_addr,
    output logic         frame_error
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        RD_DUMMY = 2'd2
    } state_t;

    state_t      state;
    logic        cs_meta;
    logic        cs_n_s;
    logic [3:0]  addr_q;
    logic        abort;
    logic        cmd_bad;
    logic [6:0]  cmd_base;
    logic [6:0]  wr_base;
    logic [15:0] rd_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_n_s  <= 1'b1;
        end else begin
            cs_meta <= spi_cs_n;
            cs_n_s  <= cs_meta;
        end
    end

    // A deselected or clock-lost link keeps the FSM parked in IDLE.
    assign abort    = cs_n_s | spi_clk_error;
    assign cmd_bad  = |rx_data[14:4];
    assign cmd_base = {rx_data[2:0], 4'b0000};
    assign wr_base  = {addr_q[2:0], 4'b0000};

    always_comb begin
        rd_value = ctrl_regs[cmd_base +: 16];
        if (rx_data[3])
            rd_value = status_in[cmd_base +: 16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= 4'h0;
            ctrl_regs     <= '0;
            tx_data       <= 16'h0000;
            tx_data_ready <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_addr       <= 3'd0;
            frame_error   <= 1'b0;
        end else begin
            tx_data_ready <= 1'b0;
            wr_strobe     <= 1'b0;
            frame_error   <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else if (rx_data_ready) begin
                case (state)
                    IDLE: begin
                        if (cmd_bad) begin
                            frame_error <= 1'b1;
                        end else if (rx_data[15]) begin
                            tx_data       <= rd_value;
                            tx_data_ready <= 1'b1;
                            state         <= RD_DUMMY;
                        end else begin
                            addr_q        <= rx_data[3:0];
                            tx_data       <= 16'hA500 | {12'h000, rx_data[3:0]};
                            tx_data_ready <= 1'b1;
                            state         <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (!addr_q[3]) begin
                            ctrl_regs[wr_base +: 16] <= rx_data;
                            wr_strobe                <= 1'b1;
                            wr_addr                  <= addr_q[2:0];
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    RD_DUMMY: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Command/register layer directly downstream of the 16-bit SPI slave transceiver. It consumes received words (`rx_data`/`rx_data_ready`) and decodes two-word write/read transactions into an internal bank of 8 read/write control registers and 8 read-only status registers. It produces the response words (`tx_data`/`tx_data_ready`) that the transceiver shifts out on MISO during the second word of each transaction.

## Interface
- No parameters; fixed map: addr 0–7 control (RW), addr 8–15 status (RO).
- `clk` in 1: system clock, same domain as the transceiver.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_cs_n` in 1: raw SPI chip select, active low; synchronized internally.
- `spi_clk_error` in 1: clock-loss pulse from the transceiver.
- `rx_data_ready` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 16: received word.
- `tx_data_ready` out 1: one-cycle pulse; transceiver loads `tx_data`.
- `tx_data` out 16: response word.
- `status_in` in 128: status regs; addr 8+k = `status_in[16k+15:16k]`.
- `ctrl_regs` out 128: control regs; addr k = `ctrl_regs[16k+15:16k]`.
- `wr_strobe` out 1: one-cycle pulse on a completed control write.
- `wr_addr` out 3: control register index written; valid with `wr_strobe`.
- `frame_error` out 1: one-cycle pulse on a protocol error.

## Operation
- Command word: bit15 = 1 read / 0 write; bits[14:4] must be 0; bits[3:0] = addr.
- Transaction: command word, then second word, within one `spi_cs_n` low period.
- Sync: `spi_cs_n` goes through a 2-flop synchronizer to give `cs_n_s`. `abort` = `cs_n_s` | `spi_clk_error`.
- FSM states: IDLE, WR_DATA, RD_DUMMY.
  - IDLE + `rx_data_ready`:
    - Bits[14:4] ≠ 0: pulse `frame_error`, stay IDLE, no tx.
    - Read command: latch read value (ctrl or status by addr, sampled this cycle). Load `tx_data` ← value, pulse `tx_data_ready`, go to RD_DUMMY.
    - Write command: latch addr. Load `tx_data` ← 16'hA500 | addr, pulse `tx_data_ready`, go to WR_DATA.
  - WR_DATA + `rx_data_ready`:
    - addr < 8: ctrl reg[addr] ← `rx_data`; pulse `wr_strobe`; `wr_addr` = addr[2:0].
    - addr ≥ 8: no write; pulse `frame_error`.
    - Both cases: go to IDLE, no tx.
  - RD_DUMMY + `rx_data_ready`: discard the word, go to IDLE.
- `abort` in any state forces IDLE the next cycle. The pending write is dropped, no strobe, no `frame_error`.
- `abort` and `rx_data_ready` in the same cycle: `abort` wins, and the word is ignored.
- A read of addr 0–7 returns the current `ctrl_regs` value, including a value written in a previous transaction.
- Control registers change only on a completed WR_DATA write. `abort` does not clear them.

## Timing
- Reset values: state IDLE, `ctrl_regs` 0, `tx_data` 0, `tx_data_ready` 0, `wr_strobe` 0, `wr_addr` 0, `frame_error` 0, `cs_n_s` 1.
- All outputs are registered.
- `rx_data_ready` at cycle N gives, at N+1:
  - `tx_data_ready`/`tx_data` for a command word;
  - `ctrl_regs` update plus `wr_strobe`/`wr_addr` for a write data word;
  - `frame_error` on an error.
- `tx_data` holds its value until the next load. `tx_data_ready` is high for exactly one cycle.
- Status sampling: `status_in` is captured in cycle N, the command's `rx_data_ready` cycle.
- Master requirement: at least 4 clk between the last SCLK falling edge of word 1 and the first SCLK rising edge of word 2. This lets the response load before the first falling-edge shift.
- Abort latency: 2–3 clk from `spi_cs_n` rising; 1 clk from `spi_clk_error`.

## Test plan
- Reset → all outputs 0, and a read of addr 3 returns 16'h0000.
- Write: words 16'h0005 then 16'hBEEF →
  - tx word 16'hA505;
  - `wr_strobe` 1 cycle, `wr_addr`=5;
  - `ctrl_regs[95:80]`=16'hBEEF.
- Read control: after the write above, words 16'h8005 then 16'h0000 → `tx_data`=16'hBEEF with one `tx_data_ready` pulse; state returns to IDLE.
- Read status: `status_in[47:32]`=16'h1234 (addr 10), words 16'h800A then dummy → `tx_data`=16'h1234. Changing `status_in` after cycle N does not alter `tx_data`.
- Errors:
  - Command 16'h0105 → `frame_error` pulse, no `tx_data_ready`.
  - Write to addr 12 (16'h000C, 16'h5555) → `frame_error` on word 2, `ctrl_regs` unchanged.
- Abort: write command 16'h0002, then raise `spi_cs_n` (or pulse `spi_clk_error`) before word 2 →
  - IDLE within 3 clk;
  - no `wr_strobe`, `ctrl_regs[47:32]` unchanged.
  - A following 16'h0002/16'h00FF transaction writes normally.
